// File: rtl/clk_shifter.sv
// clk_shifter: bit-serial shift engine driven by clk_gen's clk_posedge strobe.
// Shifts a 1..8 bit frame out on sdo_o (MSB- or LSB-first) and, when the
// receive path is built, captures the same number of bits from sdi_i.
//
// Build option: define CLK_SHIFT_RX_EN to build the receive path
// (rx_shift/rx_byte, sdi_i sampled, DATA reads return rx_byte). Without it
// DATA reads return the last byte accepted by a DATA write.
//
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   stb_i, we_i, adr_i  register bus strobe / write enable / address [5:2]
//   dat_i, dat_o, ack_o write data, registered read data, 1-cycle ack
//   clk_posedge         serial clock rising-edge strobe from clk_gen
//   sdi_i, sdo_o        serial data in / out
//   sclk_en_o           pad gate for the serial clock, high while busy
module clk_shifter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [5:2] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  input  logic       clk_posedge,
  input  logic       sdi_i,
  output logic       sdo_o,
  output logic       sclk_en_o
);
  localparam logic [3:0] CLK_SHIFT_STATUS = 4'h0;
  localparam logic [3:0] CLK_SHIFT_DATA   = 4'h1;
  localparam logic [3:0] CLK_SHIFT_CNT    = 4'h2;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [7:0]  dat_q, dat_d;
  logic        lsb_first_q, lsb_first_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  tx_q, tx_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        lsb_lat_q, lsb_lat_d;
  logic        sdo_q, sdo_d;
  logic [7:0]  data_rd;

  logic        acc, busy, cur_bit;
  logic [3:0]  eff_cnt;

`ifdef CLK_SHIFT_RX_EN
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  assign data_rd = rx_byte_q;
`else
  logic [7:0]  wr_byte_q, wr_byte_d;
  logic        unused_sdi;
  assign unused_sdi = sdi_i;
  assign data_rd    = wr_byte_q;
`endif

  // Strobes landing on the ack cycle are dropped.
  assign acc     = stb_i & ~ack_q;
  assign busy    = (state_q != ST_IDLE);
  assign cur_bit = lsb_lat_q ? tx_q[0] : tx_q[7];
  // 0 and anything above 8 both mean a full byte.
  assign eff_cnt = (cnt_q == 4'd0 || cnt_q > 4'd8) ? 4'd8 : cnt_q;

  always_comb begin
    state_d     = state_q;
    ack_d       = acc;
    dat_d       = 8'h00;
    lsb_first_d = lsb_first_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    ovr_d       = ovr_q;
    tx_d        = tx_q;
    bit_cnt_d   = bit_cnt_q;
    lsb_lat_d   = lsb_lat_q;
    sdo_d       = sdo_q;
`ifdef CLK_SHIFT_RX_EN
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
`else
    wr_byte_d   = wr_byte_q;
`endif

    if (acc && !we_i) begin
      case (adr_i)
        CLK_SHIFT_STATUS: dat_d = {4'h0, ovr_q, done_q, lsb_first_q, busy};
        CLK_SHIFT_DATA:   dat_d = data_rd;
        CLK_SHIFT_CNT:    dat_d = {4'h0, cnt_q};
        default:          dat_d = 8'h00;
      endcase
    end

    if (acc && we_i) begin
      case (adr_i)
        CLK_SHIFT_STATUS: begin
          lsb_first_d = dat_i[1];
          if (dat_i[2]) done_d = 1'b0;
          if (dat_i[3]) ovr_d  = 1'b0;
        end
        CLK_SHIFT_DATA: begin
          if (busy) begin
            ovr_d = 1'b1;
          end else begin
            tx_d      = dat_i;
            bit_cnt_d = eff_cnt;
            lsb_lat_d = lsb_first_q;  // bit order frozen for this frame
            state_d   = ST_SHIFT;
`ifdef CLK_SHIFT_RX_EN
            rx_shift_d = 8'h00;       // short frames must not inherit old bits
`else
            wr_byte_d  = dat_i;
`endif
          end
        end
        CLK_SHIFT_CNT: cnt_d = dat_i[3:0];
        default: ;
      endcase
    end

    // Placed after the bus write so a DONE-cycle set beats a W1C of done.
    case (state_q)
      ST_SHIFT: begin
        sdo_d = cur_bit;  // remembered so sdo_o holds after the frame
        if (clk_posedge) begin
          tx_d      = lsb_lat_q ? {1'b0, tx_q[7:1]} : {tx_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
`ifdef CLK_SHIFT_RX_EN
          // MSB-first fills from bit 0 so short frames end right-aligned.
          rx_shift_d = lsb_lat_q ? {sdi_i, rx_shift_q[7:1]} : {rx_shift_q[6:0], sdi_i};
`endif
          if (bit_cnt_q == 4'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef CLK_SHIFT_RX_EN
        rx_byte_d = rx_shift_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      dat_q       <= 8'h00;
      lsb_first_q <= 1'b0;
      cnt_q       <= 4'h0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      tx_q        <= 8'h00;
      bit_cnt_q   <= 4'h0;
      lsb_lat_q   <= 1'b0;
      sdo_q       <= 1'b0;
`ifdef CLK_SHIFT_RX_EN
      rx_shift_q  <= 8'h00;
      rx_byte_q   <= 8'h00;
`else
      wr_byte_q   <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      lsb_first_q <= lsb_first_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      tx_q        <= tx_d;
      bit_cnt_q   <= bit_cnt_d;
      lsb_lat_q   <= lsb_lat_d;
      sdo_q       <= sdo_d;
`ifdef CLK_SHIFT_RX_EN
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
`else
      wr_byte_q   <= wr_byte_d;
`endif
    end
  end

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign sclk_en_o = busy;
  // Live bit while shifting; last shifted bit otherwise.
  assign sdo_o     = (state_q == ST_SHIFT) ? cur_bit : sdo_q;

endmodule

// File: tb/tb_clk_shifter.sv
// Bench for clk_shifter: directed register/serial stimulus, a frame-level
// reference model compared every cycle, plus literal expectations.
module tb_clk_shifter;
  logic       clk = 1'b0;
  logic       rst_i = 1'b1, stb_i = 1'b0, we_i = 1'b0;
  logic [5:2] adr_i = 4'h0;
  logic [7:0] dat_i = 8'h00;
  logic [7:0] dat_o;
  logic       ack_o, clk_posedge = 1'b0, sdo_o, sclk_en_o;
  logic       loop = 1'b0, sdi_drv = 1'b0, sdi_w;

  int checks = 0;
  int errors = 0;

  assign sdi_w = loop ? sdo_o : sdi_drv;

  clk_shifter dut (
    .clk_i(clk), .rst_i(rst_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .clk_posedge(clk_posedge),
    .sdi_i(sdi_w), .sdo_o(sdo_o), .sclk_en_o(sclk_en_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  // A frame is the written byte plus a bit count and order; the k-th bit on
  // the wire is simply data[k] (LSB-first) or data[7-k] (MSB-first).
  int         m_phase = 0;   // 0 idle, 1 shifting, 2 done cycle
  int         m_k = 0, m_n = 8;
  logic [7:0] m_data = 0, m_rx = 0, m_rxbyte = 0, m_wrbyte = 0, m_dat = 0;
  logic [3:0] m_cnt = 0;
  logic       m_lsb = 0, m_lsb_lat = 0, m_done = 0, m_ovr = 0, m_ack = 0;
  logic       m_last_sdo = 0, m_started = 0;

  function automatic logic wire_bit(input logic [7:0] d, input logic lsb, input int k);
    return lsb ? d[k] : d[7-k];
  endfunction

  // i-th received bit lands where a frame of n bits leaves it in the byte.
  function automatic logic [7:0] rx_assemble(input logic [7:0] bits, input int n, input logic lsb);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < n; i++)
      if (lsb) r[8-n+i] = bits[i];
      else     r[n-1-i] = bits[i];
    return r;
  endfunction

  always @(posedge clk) begin : mdl
    int   old_phase;
    logic acc, old_busy;
    if (rst_i) begin
      m_phase = 0; m_k = 0; m_n = 8; m_data = 0; m_rx = 0; m_rxbyte = 0;
      m_wrbyte = 0; m_dat = 0; m_cnt = 0; m_lsb = 0; m_lsb_lat = 0;
      m_done = 0; m_ovr = 0; m_ack = 0; m_last_sdo = 0; m_started = 1;
    end else begin
      old_phase = m_phase;
      old_busy  = (m_phase != 0);
      acc       = stb_i && !m_ack;
      m_dat     = 8'h00;
      if (acc && !we_i) begin
        case (adr_i)
          4'h0: m_dat = {4'h0, m_ovr, m_done, m_lsb, old_busy};
`ifdef CLK_SHIFT_RX_EN
          4'h1: m_dat = m_rxbyte;
`else
          4'h1: m_dat = m_wrbyte;
`endif
          4'h2: m_dat = {4'h0, m_cnt};
          default: m_dat = 8'h00;
        endcase
      end
      if (acc && we_i) begin
        case (adr_i)
          4'h0: begin
            m_lsb = dat_i[1];
            if (dat_i[2]) m_done = 0;
            if (dat_i[3]) m_ovr = 0;
          end
          4'h1: begin
            if (old_busy) m_ovr = 1;
            else begin
              m_data = dat_i; m_wrbyte = dat_i; m_lsb_lat = m_lsb;
              m_n = (m_cnt == 0 || m_cnt > 8) ? 8 : int'(m_cnt);
              m_k = 0; m_rx = 0; m_phase = 1;
            end
          end
          4'h2: m_cnt = dat_i[3:0];
          default: ;
        endcase
      end
      if (old_phase == 1) begin
        m_last_sdo = wire_bit(m_data, m_lsb_lat, m_k);
        if (clk_posedge) begin
          m_rx[m_k] = sdi_w;
          m_k++;
          if (m_k == m_n) m_phase = 2;
        end
      end else if (old_phase == 2) begin
        m_done   = 1;
        m_rxbyte = rx_assemble(m_rx, m_n, m_lsb_lat);
        m_phase  = 0;
      end
      m_ack = acc;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("ack", {7'b0, ack_o}, {7'b0, m_ack});
      if (m_ack) chk("rdata", dat_o, m_dat);
      chk("sclk_en", {7'b0, sclk_en_o}, {7'b0, (m_phase != 0)});
      chk("sdo", {7'b0, sdo_o},
          {7'b0, (m_phase == 1) ? wire_bit(m_data, m_lsb_lat, m_k) : m_last_sdo});
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] seq;
  logic [7:0] rd;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    stb_i = 1; we_i = 1; adr_i = a; dat_i = d;
    tick();
    stb_i = 0; we_i = 0;
    tick();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    stb_i = 1; we_i = 0; adr_i = a;
    tick();
    d = dat_o;
    stb_i = 0;
    tick();
  endtask

  // Strobes first..last of a frame 16 cycles apart, logging the wire bit.
  task automatic run_bits(input int first, input int last, input logic toggle);
    for (int i = first; i <= last; i++) begin
      repeat (15) tick();
      seq[7-i] = sdo_o;
      sdi_drv  = toggle ? i[0] : 1'b1;
      clk_posedge = 1;
      tick();
      clk_posedge = 0;
    end
  endtask

  initial begin
    // reset
    repeat (2) tick();
    chk("rst_dat", dat_o, 8'h00);
    chk("rst_ack", {7'b0, ack_o}, 8'h00);
    chk("rst_sdo", {7'b0, sdo_o}, 8'h00);
    chk("rst_sclk", {7'b0, sclk_en_o}, 8'h00);
    rst_i = 0;
    tick();
    bus_read(4'h0, rd); chk("rst_status", rd, 8'h00);
    bus_read(4'h2, rd); chk("rst_cnt", rd, 8'h00);

    // MSB-first loopback, full byte
    loop = 1;
    bus_write(4'h2, 8'h00);
    bus_write(4'h1, 8'hA5);
    chk("load_sclk", {7'b0, sclk_en_o}, 8'h01);
    seq = 0;
    run_bits(0, 7, 1'b0);
    tick();
    chk("msb_seq", seq, 8'hA5);
    bus_read(4'h0, rd); chk("msb_status", rd, 8'h04);
    bus_read(4'h1, rd); chk("msb_data", rd, 8'hA5);
    loop = 0;

    // LSB-first, 4-bit frame, sdi held high
    bus_write(4'h0, 8'h06);
    bus_write(4'h2, 8'h04);
    bus_write(4'h1, 8'h3C);
    seq = 0;
    run_bits(0, 3, 1'b0);
    chk("lsb_done_cyc_busy", {7'b0, sclk_en_o}, 8'h01);
    tick();
    chk("lsb_idle", {7'b0, sclk_en_o}, 8'h00);
    chk("lsb_seq", seq, 8'h30);
    bus_read(4'h0, rd); chk("lsb_status", rd, 8'h06);
    bus_read(4'h1, rd);
`ifdef CLK_SHIFT_RX_EN
    chk("lsb_data", rd, 8'hF0);
`else
    chk("lsb_data", rd, 8'h3C);
`endif

    // overrun, mid-frame order change ignored, W1C
    bus_write(4'h0, 8'h06);
    bus_write(4'h2, 8'h00);
    bus_write(4'h1, 8'hC3);
    seq = 0;
    run_bits(0, 1, 1'b1);
    bus_write(4'h1, 8'h11);
    bus_write(4'h0, 8'h00);
    bus_read(4'h0, rd); chk("ovr_busy_status", rd, 8'h09);
    run_bits(2, 7, 1'b1);
    tick();
    chk("ovr_seq", seq, 8'hC3);
    bus_read(4'h0, rd); chk("ovr_status", rd, 8'h0C);
    bus_write(4'h0, 8'h0C);
    bus_read(4'h0, rd); chk("w1c_status", rd, 8'h00);

    // strobe coincident with the loading write is not counted
    stb_i = 1; we_i = 1; adr_i = 4'h1; dat_i = 8'h96; clk_posedge = 1;
    tick();
    stb_i = 0; we_i = 0; clk_posedge = 0;
    tick();
    seq = 0;
    run_bits(0, 6, 1'b0);
    repeat (3) tick();
    chk("coinc_still_busy", {7'b0, sclk_en_o}, 8'h01);
    run_bits(7, 7, 1'b0);
    tick();
    chk("coinc_seq", seq, 8'h96);
    bus_read(4'h0, rd); chk("coinc_status", rd, 8'h04);

    // reset mid-frame
    bus_write(4'h0, 8'h06);
    bus_write(4'h2, 8'h05);
    bus_write(4'h1, 8'hFF);
    run_bits(0, 2, 1'b0);
    rst_i = 1;
    tick();
    chk("abort_sclk", {7'b0, sclk_en_o}, 8'h00);
    chk("abort_sdo", {7'b0, sdo_o}, 8'h00);
    rst_i = 0;
    tick();
    bus_read(4'h0, rd); chk("abort_status", rd, 8'h00);
    bus_read(4'h1, rd); chk("abort_data", rd, 8'h00);
    bus_read(4'h2, rd); chk("abort_cnt", rd, 8'h00);

    // toggling sdi, MSB-first
    bus_write(4'h1, 8'h5A);
    seq = 0;
    run_bits(0, 7, 1'b1);
    tick();
    chk("tgl_seq", seq, 8'h5A);
    bus_read(4'h1, rd);
`ifdef CLK_SHIFT_RX_EN
    chk("tgl_data", rd, 8'h55);
`else
    chk("tgl_data", rd, 8'h5A);
`endif

    // unmapped address: acked, reads 0, writes ignored
    bus_write(4'h7, 8'hFF);
    bus_read(4'h7, rd); chk("unmapped_rd", rd, 8'h00);
    bus_read(4'h0, rd); chk("unmapped_noeff", rd, 8'h04);

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
